// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the iterative multiply/divide unit.
//   md_op_e    : operation select carried on the op port
//   md_state_e : sequencing states of the md_unit controller
package md_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,   // signed product, low half
        OP_MULH = 2'b01,   // signed product, high half
        OP_DIV  = 2'b10,   // signed quotient, truncating
        OP_REM  = 2'b11    // signed remainder, sign of dividend
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/md_iter_dp.sv
// md_iter_dp: shared 2*WIDTH accumulator for shift-add multiply and
// restoring divide, operating on unsigned magnitudes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : initialise acc = {0, a_mag} and capture b_mag
//   step       : perform one iteration (multiply or divide step)
//   is_div     : 1 selects the divide step, 0 the multiply step
//   a_mag      : multiplier / dividend magnitude
//   b_mag      : multiplicand / divisor magnitude
//   acc        : multiply -> full product; divide -> {remainder, quotient}
module md_iter_dp #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;

    // Multiply step: add multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole thing right.
    logic [WIDTH:0]     mul_sum;
    // Divide step: partial remainder shifted left by one with the next
    // dividend bit; needs one extra bit since 2*rem+1 may exceed WIDTH bits.
    logic [WIDTH:0]     rem_ext;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_ext  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = (rem_ext >= {1'b0, opb_q});
        // When div_ge holds the difference is below 2^WIDTH, so the
        // modular WIDTH-bit subtraction is exact.
        div_diff = rem_ext[WIDTH-1:0] - opb_q;

        acc_d = acc_q;
        opb_d = opb_q;
        if (load) begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            opb_d = b_mag;
        end else if (step) begin
            if (is_div) begin
                if (div_ge) begin
                    acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            opb_q <= '0;
        end else begin
            acc_q <= acc_d;
            opb_q <= opb_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative signed multiply/divide unit feeding the register
// bank write port. One operation takes WIDTH+2 busy cycles.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start, kill   : request (sampled in IDLE) / abort of in-flight op
//   op            : 00 MUL, 01 MULH, 10 DIV, 11 REM (all signed)
//   a, b, dest    : operands and destination register address
//   busy, done    : not-idle flag, one-cycle completion pulse
//   result        : result, held until the next completed op
//   wr_dir, wr_en : write address (latched dest) and write enable
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             kill,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    dest,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [AW-1:0]    wr_dir,
    output logic             wr_en
);

    localparam int CW = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    md_op_e             op_q, op_d;
    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      dir_q, dir_d;
    logic               sa_q, sa_d;        // sign of a
    logic               sb_q, sb_d;        // sign of b
    logic               bz_q, bz_d;        // divisor is zero
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;

    logic               dp_load;
    logic               dp_step;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_res;

    // Two's-complement negation of MIN yields MIN, which read as unsigned
    // is exactly |MIN|, so no extra bit is needed.
    assign a_mag   = a[WIDTH-1] ? -a : a;
    assign b_mag   = b[WIDTH-1] ? -b : b;
    assign dp_step = (state_q == S_CALC);

    md_iter_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (dp_load),
        .step   (dp_step),
        .is_div (op_q[1]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (acc)
    );

    // Sign correction of the magnitude result.
    always_comb begin
        prod_signed = (sa_q ^ sb_q) ? -acc : acc;
        quo         = acc[WIDTH-1:0];
        rem         = acc[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:  fix_res = prod_signed[WIDTH-1:0];
            OP_MULH: fix_res = prod_signed[2*WIDTH-1:WIDTH];
            // Divide by zero is forced to all ones; otherwise the natural
            // sign rules already give MIN for MIN/-1.
            OP_DIV:  fix_res = bz_q ? '1 : ((sa_q ^ sb_q) ? -quo : quo);
            // Divide by zero leaves rem = |a|, which the sign fix turns back into a.
            default: fix_res = sa_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        dir_d    = dir_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bz_d     = bz_q;
        result_d = result_q;
        done_d   = 1'b0;
        dp_load  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    dp_load = 1'b1;
                    op_d    = md_op_e'(op);
                    dir_d   = dest;
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
                    bz_d    = (b == '0);
                    count_d = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_res;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            count_q  <= '0;
            dir_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bz_q     <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bz_q     <= bz_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign wr_dir = dir_q;
    assign wr_en  = done_q && (dir_q != '0);

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard testbench for md_unit: accepted requests push the expected
// response (from a plain-arithmetic signed model); a monitor pops and
// compares on every done pulse.
module tb_md_unit;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          kill = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [AW-1:0] dest = '0;
    logic          busy, done, wr_en;
    logic [W-1:0]  result;
    logic [AW-1:0] wr_dir;

    md_unit #(.WIDTH(W), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op),
        .a(a), .b(b), .dest(dest), .busy(busy), .done(done),
        .result(result), .wr_dir(wr_dir), .wr_en(wr_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  res;
        logic [AW-1:0] dest;
        int            e0;
    } exp_t;

    exp_t sb_q[$];
    int   acc_cyc_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference model: signed 32-bit semantics via 64-bit arithmetic.
    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint       p;
        logic [63:0]  pu;
        logic [W-1:0] r;
        p  = longint'($signed(x)) * longint'($signed(y));
        pu = p;
        case (o)
            2'b00: r = pu[31:0];
            2'b01: r = pu[63:32];
            2'b10: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(x) / $signed(y);
            end
            default: begin
                if (y == 0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
                else r = $signed(x) % $signed(y);
            end
        endcase
        return r;
    endfunction

    // Request tracker: a request presented while idle, without kill, is accepted
    // at the next edge (inputs only change just after posedge, so this is stable).
    always @(negedge clk) begin
        if (rst_n && !busy && start && !kill) begin
            sb_q.push_back('{res: model(op, a, b), dest: dest, e0: cyc + 1});
            acc_cyc_q.push_back(cyc + 1);
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                chk("done_single_cycle", 64'(prev_done), 64'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: result %h, no request outstanding", result);
                end else begin
                    e = sb_q.pop_front();
                    $display("txn done cyc=%0d result=%h exp=%h wr_dir=%0d wr_en=%0b", cyc, result, e.res, wr_dir, wr_en);
                    chk("result", 64'(result), 64'(e.res));
                    chk("wr_dir", 64'(wr_dir), 64'(e.dest));
                    chk("wr_en", 64'(wr_en), 64'(e.dest != 0));
                    chk("latency", 64'(cyc - e.e0), 64'(W + 1));
                end
            end else if (wr_en) begin
                chk("wr_en_without_done", 64'(wr_en), 64'd0);
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!busy) break;
            n++;
            if (n > 200) begin
                $display("FAIL wait_idle: busy stuck high, got 1 expected 0");
                errors++;
                checks++;
                break;
            end
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic [AW-1:0] d);
        wait_idle();
        op = o; a = x; b = y; dest = d; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    logic [W-1:0] held;
    logic [W-1:0] ra, rb;
    logic [W-1:0] specials [8];

    initial begin
        specials = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h8000_0001};

        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_result", 64'(result), 0);
        chk("rst_wr_dir", 64'(wr_dir), 0);
        chk("rst_wr_en", 64'(wr_en), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases
        issue(2'b00, 32'd7, -32'sd3, 5'd5);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1);
        issue(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd2);
        issue(2'b10, -32'sd7, 32'd2, 5'd3);
        issue(2'b11, -32'sd7, 32'd2, 5'd4);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        issue(2'b10, 32'd9, 32'd0, 5'd8);
        issue(2'b11, 32'd9, 32'd0, 5'd9);
        issue(2'b11, -32'sd9, 32'd0, 5'd10);
        issue(2'b00, 32'd2, 32'd3, 5'd0);

        // kill together with start while idle: ignored
        wait_idle();
        op = 2'b00; a = 32'd5; b = 32'd5; dest = 5'd3; start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        chk("start_with_kill_ignored", 64'(busy), 0);

        // kill mid-calculation
        wait_idle();
        held = result;
        issue(2'b10, 32'd1000, 32'd7, 5'd11);
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_to_idle", 64'(busy), 0);
        sb_q.delete();
        repeat (40) @(posedge clk);
        #1;
        chk("kill_result_kept", 64'(result), 64'(held));

        // asynchronous reset mid-op
        issue(2'b00, 32'd123, 32'd456, 5'd12);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 0);
        chk("async_rst_result", 64'(result), 0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("no_done_after_rst", 64'(sb_q.size()), 0);

        // start held high: only idle-state acceptance
        wait_idle();
        acc_cyc_q.delete();
        op = 2'b00; a = 32'hFFFF_FFF0; b = 32'd3; dest = 5'd13; start = 1'b1;
        repeat (2 * (W + 3) + 5) @(posedge clk);
        #1;
        start = 1'b0;
        chk("hold_accept_count", 64'(acc_cyc_q.size()), 3);
        for (int i = 1; i < acc_cyc_q.size(); i++) begin
            chk("hold_spacing_min", 64'(acc_cyc_q[i] - acc_cyc_q[i-1] >= W + 2), 1);
            chk("hold_spacing_max", 64'(acc_cyc_q[i] - acc_cyc_q[i-1] <= W + 3), 1);
        end

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
            case ($urandom_range(0, 4))
                0: rb = specials[$urandom_range(0, 7)];
                1: rb = W'($signed(8'($urandom)));
                default: rb = $urandom;
            endcase
            issue(2'($urandom_range(0, 3)), ra, rb, AW'($urandom_range(0, 31)));
        end

        // Drain
        for (int n = 0; n < 200 && sb_q.size() != 0; n++) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
